// File: rtl/stepper_phase_decoder.sv
// Stepper coil decoder: 2-flop sync, stability filter, half-step phase tracking into a signed position.
// Latency STABLE_CYCLES+3 edges from a stable pin change to outputs; no backpressure (free-running).
module stepper_phase_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int POS_WIDTH     = 16
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 jb1,
  input  logic                 jb2,
  input  logic                 jb3,
  input  logic                 jb4,
  input  logic                 err_clr,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_pulse,
  output logic                 dir,
  output logic [2:0]           phase_idx,
  output logic                 locked,
  output logic                 coils_off,
  output logic                 err
);

  typedef enum logic {UNLOCKED, TRACKING} state_t;

  localparam logic [8:0] CNT_FIRE = 9'(STABLE_CYCLES);

  state_t               state, state_nxt;
  logic [3:0]           sync1, sync2, cand;
  logic [8:0]           cnt;
  logic                 accept;
  logic                 legal;
  logic [2:0]           ph;
  logic [2:0]           delta;
  logic [2:0]           back;
  logic [POS_WIDTH-1:0] pos_nxt;
  logic [2:0]           phase_nxt;
  logic                 dir_nxt, step_nxt, coils_nxt, err_set;

  // cnt==0 means no candidate yet; it saturates at CNT_FIRE+1 so each stable run fires once.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
      cand  <= 4'd0;
      cnt   <= 9'd0;
    end else begin
      sync1 <= {jb1, jb2, jb3, jb4};
      sync2 <= sync1;
      if (sync2 != cand || cnt == 9'd0) begin
        cand <= sync2;
        cnt  <= 9'd1;
      end else if (cnt <= CNT_FIRE) begin
        cnt <= cnt + 9'd1;
      end
    end
  end

  assign accept = (sync2 == cand) && (cnt == CNT_FIRE);

  always_comb begin
    legal = 1'b1;
    ph    = 3'd0;
    case (cand)
      4'b1000: ph = 3'd0;
      4'b1100: ph = 3'd1;
      4'b0100: ph = 3'd2;
      4'b0110: ph = 3'd3;
      4'b0010: ph = 3'd4;
      4'b0011: ph = 3'd5;
      4'b0001: ph = 3'd6;
      4'b1001: ph = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  assign delta = ph - phase_idx;
  assign back  = 3'd0 - delta;

  always_comb begin
    state_nxt = state;
    pos_nxt   = position;
    phase_nxt = phase_idx;
    dir_nxt   = dir;
    step_nxt  = 1'b0;
    coils_nxt = coils_off;
    err_set   = 1'b0;
    if (accept) begin
      if (cand == 4'b0000) begin
        coils_nxt = 1'b1;
      end else if (legal) begin
        coils_nxt = 1'b0;
        phase_nxt = ph;
        if (state == UNLOCKED) begin
          state_nxt = TRACKING;
        end else begin
          case (delta)
            3'd1, 3'd2: begin
              pos_nxt  = position + POS_WIDTH'(delta);
              dir_nxt  = 1'b1;
              step_nxt = 1'b1;
            end
            3'd6, 3'd7: begin
              pos_nxt  = position - POS_WIDTH'(back);
              dir_nxt  = 1'b0;
              step_nxt = 1'b1;
            end
            3'd3, 3'd4, 3'd5: err_set = 1'b1;
            default: ;
          endcase
        end
      end else begin
        err_set   = 1'b1;
        coils_nxt = 1'b0;
        state_nxt = UNLOCKED;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state      <= UNLOCKED;
      position   <= '0;
      phase_idx  <= 3'd0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      coils_off  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      position   <= pos_nxt;
      phase_idx  <= phase_nxt;
      dir        <= dir_nxt;
      step_pulse <= step_nxt;
      coils_off  <= coils_nxt;
      err        <= err_set | (err & ~err_clr);
    end
  end

  assign locked = (state == TRACKING);

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Randomized and directed bench for stepper_phase_decoder, checked every cycle against a behavioural model.
module tb_stepper_phase_decoder;

  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] pins;
  logic       err_clr;
  logic       checking;

  logic [15:0] pos_a;
  logic        step_a, dir_a, locked_a, coils_a, err_a;
  logic [2:0]  phase_a;
  logic [3:0]  pos_b;
  logic        step_b, dir_b, locked_b, coils_b, err_b;
  logic [2:0]  phase_b;

  stepper_phase_decoder #(.STABLE_CYCLES(S), .POS_WIDTH(16)) u_a (
    .CLK100MHZ(clk), .reset(rst_n),
    .jb1(pins[3]), .jb2(pins[2]), .jb3(pins[1]), .jb4(pins[0]),
    .err_clr(err_clr), .position(pos_a), .step_pulse(step_a), .dir(dir_a),
    .phase_idx(phase_a), .locked(locked_a), .coils_off(coils_a), .err(err_a)
  );

  stepper_phase_decoder #(.STABLE_CYCLES(S), .POS_WIDTH(4)) u_b (
    .CLK100MHZ(clk), .reset(rst_n),
    .jb1(pins[3]), .jb2(pins[2]), .jb3(pins[1]), .jb4(pins[0]),
    .err_clr(err_clr), .position(pos_b), .step_pulse(step_b), .dir(dir_b),
    .phase_idx(phase_b), .locked(locked_b), .coils_off(coils_b), .err(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: pins reach the filter two edges late; a value seen at S+1 consecutive
  // edges is accepted once, then interpreted by phase arithmetic modulo 8.
  logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [3:0] dly [2];
  logic [3:0] run_val;
  int         run;
  int         m_pos, m_phase;
  bit         m_locked, m_coils, m_err, m_dir, m_step;

  always @(posedge clk) begin : model
    logic [3:0] v;
    int ph, d;
    bit eset;
    if (!rst_n) begin
      dly[0] = 4'd0; dly[1] = 4'd0; run = 0; run_val = 4'd0;
      m_pos = 0; m_phase = 0; m_locked = 0; m_coils = 0; m_err = 0; m_dir = 0; m_step = 0;
    end else begin
      v = dly[0];
      dly[0] = dly[1];
      dly[1] = pins;
      if (run > 0 && v == run_val) run++;
      else begin run_val = v; run = 1; end
      m_step = 0;
      eset = 0;
      if (run == S + 1) begin
        ph = -1;
        for (int i = 0; i < 8; i++) if (pat[i] == v) ph = i;
        if (v == 4'b0000) m_coils = 1;
        else if (ph >= 0) begin
          m_coils = 0;
          if (!m_locked) m_locked = 1;
          else begin
            d = (ph - m_phase + 8) % 8;
            if (d == 1 || d == 2) begin m_pos += d; m_dir = 1; m_step = 1; end
            else if (d >= 6) begin m_pos -= (8 - d); m_dir = 0; m_step = 1; end
            else if (d >= 3) eset = 1;
          end
          m_phase = ph;
        end else begin
          eset = 1; m_locked = 0; m_coils = 0;
        end
      end
      m_err = eset | (m_err & !err_clr);
    end
  end

  int pulses = 0;

  always @(posedge clk) begin : compare
    logic [31:0] mp;
    #1;
    if (checking) begin
      mp = m_pos;
      chk("cycle_a", {8'd0, pos_a, step_a, dir_a, phase_a, locked_a, coils_a, err_a},
          {8'd0, mp[15:0], m_step, m_dir, 3'(m_phase), m_locked, m_coils, m_err});
      chk("cycle_b", {20'd0, pos_b, step_b, dir_b, phase_b, locked_b, coils_b, err_b},
          {20'd0, mp[3:0], m_step, m_dir, 3'(m_phase), m_locked, m_coils, m_err});
      if (step_a) pulses++;
    end
  end

  task automatic hold(input logic [3:0] p, input int n);
    pins = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic lock_latency(input string name);
    int lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!locked_a && lat < 40);
    chk(name, lat, S + 3);
  endtask

  int p0;

  initial begin
    rst_n = 1'b0; pins = 4'd0; err_clr = 1'b0; checking = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pos", pos_a, 0);
    chk("reset_flags", {locked_a, coils_a, err_a, step_a, dir_a, phase_a}, 0);
    rst_n = 1'b1;
    hold(4'b0000, 10);
    chk("coils_after_reset", coils_a, 1);

    // first lock and its latency
    pins = 4'b1000;
    lock_latency("lock_latency");
    @(negedge clk);
    chk("lock_no_step", pulses, 0);
    hold(4'b1000, 4);
    p0 = pulses;
    hold(4'b1100, 10);
    hold(4'b0100, 10);
    chk("fwd_pos", pos_a, 2);
    chk("fwd_model_pos", m_pos, 2);
    chk("fwd_phase", phase_a, 2);
    chk("fwd_dir", dir_a, 1);
    chk("fwd_pulses", pulses - p0, 2);

    p0 = pulses;
    hold(4'b1100, 10);
    hold(4'b1000, 10);
    chk("rev_pos", pos_a, 0);
    chk("rev_dir", dir_a, 0);
    chk("rev_pulses", pulses - p0, 2);

    p0 = pulses;
    hold(4'b1100, 2);
    hold(4'b1000, 10);
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_pos", pos_a, 0);

    hold(4'b0010, 10);
    chk("amb_err", err_a, 1);
    chk("amb_pos", pos_a, 0);
    chk("amb_phase", phase_a, 4);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("err_clr", err_a, 0);

    hold(4'b1010, 10);
    chk("illegal_err", err_a, 1);
    chk("illegal_unlock", locked_a, 0);
    p0 = pulses;
    hold(4'b1000, 10);
    chk("relock", locked_a, 1);
    chk("relock_no_step", pulses - p0, 0);

    hold(4'b1100, 10); hold(4'b0100, 10); hold(4'b0110, 10);
    hold(4'b0000, 10);
    chk("coils_on_zero", coils_a, 1);
    chk("zero_pos", pos_a, 3);
    hold(4'b0010, 10);
    chk("coils_cleared", coils_a, 0);
    chk("after_zero_pos", pos_a, 4);
    hold(4'b0011, 10); hold(4'b0001, 10); hold(4'b1001, 10);
    chk("narrow_pos7", pos_b, 4'd7);
    hold(4'b1000, 10);
    chk("narrow_wrap", pos_b, 4'h8);
    chk("wide_pos8", pos_a, 8);

    // error event coinciding with err_clr keeps err set for that edge
    err_clr = 1'b1; pins = 4'b1111;
    repeat (S + 3) @(posedge clk);
    #2;
    chk("err_set_wins", err_a, 1);
    @(negedge clk); err_clr = 1'b0;

    // reset in the middle of a stability count discards the candidate
    hold(4'b1000, 10);
    pins = 4'b1100;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lock_latency("reset_midcount_latency");
    chk("reset_midcount_pos", pos_a, 0);
    chk("reset_midcount_phase", phase_a, 1);

    for (int it = 0; it < 400; it++) begin
      logic [3:0] p;
      int r;
      r = $urandom_range(0, 99);
      if (r < 72) p = pat[$urandom_range(0, 7)];
      else if (r < 82) p = 4'b0000;
      else p = 4'($urandom);
      err_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      end
      hold(p, $urandom_range(1, 12));
    end
    err_clr = 1'b0;
    hold(pins, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
